bpu_train_scheduler: RTL and testbench
======================================

Name: bpu_train_scheduler

Overview:
- Queues commit-time training packets from the FTQ and issues them one per cycle to the FTB/TAGE update port.
- The FTB and TAGE tables use single-ported storage shared between prediction queries and training updates. This block arbitrates that port.
- Query normally has priority. A starvation counter forces an update slot and stalls the BPU front end for one cycle.
- Sits between the FTQ training output and the BPU update inputs.

Parameters:
- TRAIN_QUEUE_DEPTH, 4, number of buffered training packets (power of two, ≥2).
- STARVE_LIMIT, 8, consecutive cycles a non-empty queue may lose arbitration before a forced update.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- train_valid_i  input  1  FTQ offers a training packet
- train_meta_i  input  $bits(ftq_bpu_meta_t)  training packet
- train_ready_o  output  1  queue can accept; a push occurs when valid&ready
- query_req_i  input  1  BPU needs the shared table port this cycle
- query_stall_o  output  1  BPU must hold pc and not query this cycle
- upd_valid_o  output  1  update issued to FTB/TAGE this cycle
- upd_meta_o  output  $bits(ftq_bpu_meta_t)  packet being issued (queue head)
- queue_cnt_o  output  $clog2(TRAIN_QUEUE_DEPTH)+1  current occupancy
- starve_cnt_o  output  $clog2(STARVE_LIMIT)+1  current starvation count (debug/PMU)

Behaviour:
- Reset: queue empty, rd/wr pointers 0, starve_cnt 0, state IDLE. train_ready_o=1, query_stall_o=0, upd_valid_o=0, upd_meta_o=0, queue_cnt_o=0. Reset mid-operation discards all queued packets.
- Queue:
  - Circular FIFO with registered count.
  - train_ready_o = (count != TRAIN_QUEUE_DEPTH). Ready is not combinationally raised by a same-cycle pop.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Pointers wrap modulo TRAIN_QUEUE_DEPTH.
- No bypass: a packet pushed in cycle N is issued at the earliest in cycle N+1.
- Output stability: upd_meta_o = head entry when count>0, else 0. It is combinational from FIFO storage and the head pointer.
- FSM states: IDLE (count==0), WAIT (count>0, query won), FORCE (starve_cnt==STARVE_LIMIT).
- Issue rule, per cycle with count>0:
  - IDLE/WAIT, query_req_i=0: upd_valid_o=1, pop, starve_cnt<=0.
  - IDLE/WAIT, query_req_i=1: upd_valid_o=0, starve_cnt<=starve_cnt+1, saturating at STARVE_LIMIT. When it reaches STARVE_LIMIT, next state is FORCE.
  - FORCE: upd_valid_o=1, query_stall_o=1 regardless of query_req_i, pop, starve_cnt<=0. Next state is IDLE or WAIT by post-pop count.
  - query_stall_o is 0 in every other case.
- count==0: upd_valid_o=0, starve_cnt<=0, state IDLE.
- Back-to-back forced updates cannot occur. After a FORCE cycle at least STARVE_LIMIT further query-won cycles are required before the next FORCE.
- Backend flush has no input here. Training packets are post-commit and are never dropped by flush.
- Full + push attempt: train_ready_o=0, no push, FTQ holds its packet.
- Full + pop in the same cycle: the pop happens and ready rises next cycle.
- Update ordering is strict FIFO. This guarantees RAS push/pop order and FTB dirty-invalidate order as committed.

Test Plan:
- Reset, then push 1 packet (start_pc=0x1c000000) with query_req_i=0 → upd_valid_o=1 exactly one cycle later with matching upd_meta_o; queue_cnt_o returns 0.
- query_req_i held 1, push 1 packet, STARVE_LIMIT=8:
  - starve_cnt_o climbs 1..8 over 8 cycles with upd_valid_o=0.
  - 9th cycle: upd_valid_o=1, query_stall_o=1.
  - Following cycle: query_stall_o=0, starve_cnt_o=0.
- Push 5 packets back-to-back while query_req_i=1, depth 4:
  - train_ready_o drops after the 4th push and the 5th is held.
  - On the first issue, ready rises the next cycle and the 5th is accepted.
  - Issue order is 1..5.
- Simultaneous push and pop at count=2 with query_req_i=0 → count stays 2 and head advances. Pointer wrap is checked after 10 packets, with no loss or duplication against a scoreboard.
- Alternate query_req_i 1/0 each cycle with 3 queued → updates issue on each 0-cycle, starve_cnt never exceeds 1, query_stall_o stays 0.
- Assert rst mid-stream with 3 queued and starve_cnt=5 → next cycle count=0, starve_cnt=0, upd_valid_o=0, train_ready_o=1, and none of the old packets are ever issued.

Source files
------------

// File: rtl/bpu_train_scheduler.sv
// Commit-time training queue that shares the single-ported FTB/TAGE storage with
// prediction queries, letting queries win until a starvation limit forces an update.

package bpu_train_pkg;

    typedef struct packed {
        logic [31:0] start_pc;
        logic [31:0] target;
        logic [1:0]  br_taken;
        logic [1:0]  br_mask;
        logic [1:0]  ras_action;
    } ftq_bpu_meta_t;

    localparam int META_W = $bits(ftq_bpu_meta_t);

endpackage

module bpu_train_scheduler
    import bpu_train_pkg::*;
#(
    parameter int TRAIN_QUEUE_DEPTH = 4,
    parameter int STARVE_LIMIT      = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                train_valid_i,
    input  logic [META_W-1:0]                   train_meta_i,
    output logic                                train_ready_o,
    input  logic                                query_req_i,
    output logic                                query_stall_o,
    output logic                                upd_valid_o,
    output logic [META_W-1:0]                   upd_meta_o,
    output logic [$clog2(TRAIN_QUEUE_DEPTH):0]  queue_cnt_o,
    output logic [$clog2(STARVE_LIMIT):0]       starve_cnt_o
);

    localparam int PW = $clog2(TRAIN_QUEUE_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TRAIN_QUEUE_DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FORCE
    } state_t;

    logic [META_W-1:0] mem [TRAIN_QUEUE_DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic [SW-1:0]     starve_cnt;
    logic [SW-1:0]     starve_nxt;
    state_t            state;
    logic              not_empty;
    logic              push;
    logic              pop;

    assign not_empty     = (count != '0);
    assign train_ready_o = (count != DEPTH_C);
    assign push          = train_valid_i & train_ready_o;
    // FORCE steals the port from the query; otherwise the update only goes when the BPU is idle.
    assign pop           = not_empty & ((state == FORCE) | ~query_req_i);

    assign upd_valid_o   = pop;
    assign query_stall_o = not_empty & (state == FORCE);
    assign upd_meta_o    = not_empty ? mem[rd_ptr] : '0;
    assign queue_cnt_o   = count;
    assign starve_cnt_o  = starve_cnt;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end

        starve_nxt = '0;
        if (not_empty && !pop) begin
            starve_nxt = (starve_cnt == LIMIT_C) ? starve_cnt : starve_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= train_meta_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            starve_cnt <= '0;
            state      <= IDLE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            if (count_nxt == '0) begin
                state <= IDLE;
            end else if (starve_nxt == LIMIT_C) begin
                state <= FORCE;
            end else begin
                state <= WAIT;
            end
        end
    end

endmodule

// File: tb/tb_bpu_train_scheduler.sv
// Directed bench for bpu_train_scheduler: vector table for queue/issue timing plus
// hand sequences for starvation, pointer wrap, alternating queries and mid-stream reset.

module tb_bpu_train_scheduler;
    import bpu_train_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 train_valid_i;
    logic [META_W-1:0]    train_meta_i;
    logic                 train_ready_o;
    logic                 query_req_i;
    logic                 query_stall_o;
    logic                 upd_valid_o;
    logic [META_W-1:0]    upd_meta_o;
    logic [2:0]           queue_cnt_o;
    logic [3:0]           starve_cnt_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        query;
        logic        exp_ready;
        logic        exp_uv;
        logic        exp_stall;
        logic [2:0]  exp_cnt;
        logic [3:0]  exp_starve;
        logic [31:0] exp_head;
    } vec_t;

    vec_t vecs[$];

    bpu_train_scheduler #(
        .TRAIN_QUEUE_DEPTH(4),
        .STARVE_LIMIT(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .train_valid_i(train_valid_i),
        .train_meta_i(train_meta_i),
        .train_ready_o(train_ready_o),
        .query_req_i(query_req_i),
        .query_stall_o(query_stall_o),
        .upd_valid_o(upd_valid_o),
        .upd_meta_o(upd_meta_o),
        .queue_cnt_o(queue_cnt_o),
        .starve_cnt_o(starve_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [META_W-1:0] makeMeta(input logic [31:0] pc);
        ftq_bpu_meta_t m;
        m.start_pc   = pc;
        m.target     = pc + 32'h40;
        m.br_taken   = pc[3:2];
        m.br_mask    = pc[5:4];
        m.ras_action = pc[7:6];
        return m;
    endfunction

    function automatic logic [META_W-1:0] expMeta(input logic [31:0] pc);
        return (pc == 32'h0) ? '0 : makeMeta(pc);
    endfunction

    task automatic addVec(input logic v, input logic [31:0] pc, input logic q,
                          input logic rdy, input logic uv, input logic st,
                          input logic [2:0] cnt, input logic [3:0] stv,
                          input logic [31:0] head);
        vec_t e;
        e.valid = v; e.pc = pc; e.query = q;
        e.exp_ready = rdy; e.exp_uv = uv; e.exp_stall = st;
        e.exp_cnt = cnt; e.exp_starve = stv; e.exp_head = head;
        vecs.push_back(e);
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic q);
        @(negedge clk);
        train_valid_i = v;
        train_meta_i  = v ? makeMeta(pc) : '0;
        query_req_i   = q;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] alt_pcs [3];
        logic [31:0] sb[$];
        int          sent;
        int          mcnt;
        bit          exp_issue;
        bit          accepted;
        bit          q;
        logic [31:0] pc;
        bit          stale_issue;

        rst           = 1'b1;
        train_valid_i = 1'b0;
        train_meta_i  = '0;
        query_req_i   = 1'b0;

        // Single packet round trip, then a five-packet burst against a depth-4 queue,
        // then simultaneous push/pop at occupancy 2.
        addVec(0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h1c000000,  0, 1, 0, 0, 0, 0, 32'h0);
        addVec(0, 32'h0,         0, 1, 1, 0, 1, 0, 32'h1c000000);
        addVec(0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h1c000044,  1, 1, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h1c0000a8,  1, 1, 0, 0, 1, 0, 32'h1c000044);
        addVec(1, 32'h1c0001cc,  1, 1, 0, 0, 2, 1, 32'h1c000044);
        addVec(1, 32'h1c0002f0,  1, 1, 0, 0, 3, 2, 32'h1c000044);
        addVec(1, 32'h1c000314,  1, 0, 0, 0, 4, 3, 32'h1c000044);
        addVec(1, 32'h1c000314,  0, 0, 1, 0, 4, 4, 32'h1c000044);
        addVec(1, 32'h1c000314,  1, 1, 0, 0, 3, 0, 32'h1c0000a8);
        addVec(0, 32'h0,         0, 0, 1, 0, 4, 1, 32'h1c0000a8);
        addVec(0, 32'h0,         0, 1, 1, 0, 3, 0, 32'h1c0001cc);
        addVec(0, 32'h0,         0, 1, 1, 0, 2, 0, 32'h1c0002f0);
        addVec(0, 32'h0,         0, 1, 1, 0, 1, 0, 32'h1c000314);
        addVec(0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h20000010,  1, 1, 0, 0, 0, 0, 32'h0);
        addVec(1, 32'h20000024,  1, 1, 0, 0, 1, 0, 32'h20000010);
        addVec(1, 32'h20000038,  0, 1, 1, 0, 2, 1, 32'h20000010);
        addVec(0, 32'h0,         0, 1, 1, 0, 2, 0, 32'h20000024);
        addVec(0, 32'h0,         0, 1, 1, 0, 1, 0, 32'h20000038);
        addVec(0, 32'h0,         0, 1, 0, 0, 0, 0, 32'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].valid, vecs[i].pc, vecs[i].query);
            checkOutput($sformatf("vec%0d_ready", i), 80'(train_ready_o), 80'(vecs[i].exp_ready));
            checkOutput($sformatf("vec%0d_upd_valid", i), 80'(upd_valid_o), 80'(vecs[i].exp_uv));
            checkOutput($sformatf("vec%0d_stall", i), 80'(query_stall_o), 80'(vecs[i].exp_stall));
            checkOutput($sformatf("vec%0d_cnt", i), 80'(queue_cnt_o), 80'(vecs[i].exp_cnt));
            checkOutput($sformatf("vec%0d_starve", i), 80'(starve_cnt_o), 80'(vecs[i].exp_starve));
            checkOutput($sformatf("vec%0d_meta", i), 80'(upd_meta_o), 80'(expMeta(vecs[i].exp_head)));
        end

        // Starvation: query held high, one packet waits 8 cycles then is forced out.
        applyStimulus(1, 32'h1c000800, 1);
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 32'h0, 1);
            checkOutput($sformatf("starve%0d_upd_valid", k), 80'(upd_valid_o), 80'(0));
            checkOutput($sformatf("starve%0d_stall", k), 80'(query_stall_o), 80'(0));
            checkOutput($sformatf("starve%0d_cnt", k), 80'(starve_cnt_o), 80'(k - 1));
        end
        applyStimulus(0, 32'h0, 1);
        checkOutput("force_upd_valid", 80'(upd_valid_o), 80'(1));
        checkOutput("force_stall", 80'(query_stall_o), 80'(1));
        checkOutput("force_starve", 80'(starve_cnt_o), 80'(8));
        checkOutput("force_meta", 80'(upd_meta_o), 80'(makeMeta(32'h1c000800)));
        applyStimulus(0, 32'h0, 1);
        checkOutput("post_force_stall", 80'(query_stall_o), 80'(0));
        checkOutput("post_force_starve", 80'(starve_cnt_o), 80'(0));
        checkOutput("post_force_cnt", 80'(queue_cnt_o), 80'(0));
        checkOutput("post_force_upd_valid", 80'(upd_valid_o), 80'(0));

        // Ten packets through the ring with a 1-in-3 query pattern, against a scoreboard.
        sent = 0;
        mcnt = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (sent == 10 && mcnt == 0) break;
            q  = (cyc % 3 == 0);
            pc = 32'h30000000 + 32'(sent) * 32'h104;
            applyStimulus(sent < 10, pc, q);
            exp_issue = (mcnt > 0) && !q;
            accepted  = (sent < 10) && (mcnt < 4);
            checkOutput($sformatf("wrap%0d_cnt", cyc), 80'(queue_cnt_o), 80'(mcnt));
            checkOutput($sformatf("wrap%0d_ready", cyc), 80'(train_ready_o), 80'(mcnt < 4));
            checkOutput($sformatf("wrap%0d_upd_valid", cyc), 80'(upd_valid_o), 80'(exp_issue));
            if (exp_issue) begin
                checkOutput($sformatf("wrap%0d_meta", cyc), 80'(upd_meta_o), 80'(makeMeta(sb[0])));
                void'(sb.pop_front());
            end
            if (accepted) begin
                sb.push_back(pc);
                sent++;
            end
            mcnt = mcnt + int'(accepted) - int'(exp_issue);
        end
        checkOutput("wrap_all_sent", 80'(sent), 80'(10));
        checkOutput("wrap_sb_drained", 80'(sb.size()), 80'(0));

        // Alternating query with three queued packets.
        alt_pcs[0] = 32'h40000104;
        alt_pcs[1] = 32'h40000208;
        alt_pcs[2] = 32'h4000030c;
        for (int i = 0; i < 3; i++) applyStimulus(1, alt_pcs[i], 1);
        for (int i = 0; i < 6; i++) begin
            q = (i % 2 == 1);
            applyStimulus(0, 32'h0, q);
            checkOutput($sformatf("alt%0d_upd_valid", i), 80'(upd_valid_o), 80'(!q));
            checkOutput($sformatf("alt%0d_stall", i), 80'(query_stall_o), 80'(0));
            if (!q) checkOutput($sformatf("alt%0d_meta", i), 80'(upd_meta_o), 80'(makeMeta(alt_pcs[i/2])));
            if (i > 0) checkOutput($sformatf("alt%0d_starve_le1", i), 80'(starve_cnt_o <= 4'd1), 80'(1));
        end

        // Reset mid-stream with three queued and starve_cnt at 5.
        applyStimulus(1, 32'h50000010, 1);
        applyStimulus(1, 32'h50000024, 1);
        applyStimulus(1, 32'h50000038, 1);
        repeat (3) applyStimulus(0, 32'h0, 1);
        applyStimulus(0, 32'h0, 1);
        rst = 1'b1;
        checkOutput("prerst_cnt", 80'(queue_cnt_o), 80'(3));
        checkOutput("prerst_starve", 80'(starve_cnt_o), 80'(5));
        applyStimulus(0, 32'h0, 0);
        rst = 1'b0;
        checkOutput("rst_cnt", 80'(queue_cnt_o), 80'(0));
        checkOutput("rst_starve", 80'(starve_cnt_o), 80'(0));
        checkOutput("rst_upd_valid", 80'(upd_valid_o), 80'(0));
        checkOutput("rst_ready", 80'(train_ready_o), 80'(1));
        checkOutput("rst_stall", 80'(query_stall_o), 80'(0));
        checkOutput("rst_meta", 80'(upd_meta_o), 80'(0));
        stale_issue = 1'b0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 32'h0, 0);
            if (upd_valid_o) stale_issue = 1'b1;
        end
        checkOutput("rst_no_stale_issue", 80'(stale_issue), 80'(0));
        applyStimulus(1, 32'h5000044c, 0);
        applyStimulus(0, 32'h0, 0);
        checkOutput("rst_new_upd_valid", 80'(upd_valid_o), 80'(1));
        checkOutput("rst_new_meta", 80'(upd_meta_o), 80'(makeMeta(32'h5000044c)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
